dmem_arbiter: RTL



---
 rtl/mem_pkg.sv | 13 +
 rtl/sat_counter.sv | 20 ++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory arbiter.
// Grant ids and arbiter FSM states.
package mem_pkg;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous reset.
// Ports: clk, reset (sync, active-high), en, count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing DataMemory between core and host.
// Ports: cpu_* core side, host_* loader side, mem_* memory side,
// cpu_stall to freeze the core, stall_cnt saturating stall count.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_LOCK = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wd,
    output logic [31:0]      cpu_rd,
    output logic             cpu_ready,
    output logic             cpu_stall,
    input  logic             host_req,
    input  logic             host_we,
    input  logic             host_lock,
    input  logic [31:0]      host_addr,
    input  logic [31:0]      host_wd,
    output logic [31:0]      host_rd,
    output logic             host_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             mem_we,
    input  logic [31:0]      mem_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);
    localparam bit         LOCK_EN   = (MAX_LOCK > 1);

    arb_state_t state, state_nx;
    logic       last_grant, last_grant_nx;
    logic [7:0] lock_cnt, lock_cnt_nx;
    logic       gnt_cpu, gnt_host;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ARB;
            last_grant <= GNT_HOST;
            lock_cnt   <= 8'd0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            lock_cnt   <= lock_cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        lock_cnt_nx   = lock_cnt;
        gnt_cpu       = 1'b0;
        gnt_host      = 1'b0;
        unique case (state)
            ST_ARB: begin
                if (cpu_req && host_req) begin
                    // tie goes to whoever did not win last
                    gnt_cpu  = (last_grant == GNT_HOST);
                    gnt_host = (last_grant == GNT_CPU);
                end else begin
                    gnt_cpu  = cpu_req;
                    gnt_host = host_req;
                end
                if (gnt_cpu) begin
                    last_grant_nx = GNT_CPU;
                end
                if (gnt_host) begin
                    last_grant_nx = GNT_HOST;
                    if (host_lock && LOCK_EN) begin
                        state_nx    = ST_LOCK;
                        lock_cnt_nx = 8'd1;
                    end
                end
            end
            ST_LOCK: begin
                // idle lock cycles still burn budget
                gnt_host    = host_req;
                lock_cnt_nx = lock_cnt + 8'd1;
                if (!host_lock || (lock_cnt == LOCK_LAST)) begin
                    state_nx      = ST_ARB;
                    last_grant_nx = GNT_HOST;
                end
            end
            default: begin
                state_nx = ST_ARB;
            end
        endcase
    end

    assign cpu_ready  = gnt_cpu;
    assign host_ready = gnt_host;
    assign cpu_stall  = cpu_req & ~gnt_cpu;

    // ungranted cycles park the mux on the CPU port
    assign mem_addr = gnt_host ? host_addr : cpu_addr;
    assign mem_wd   = gnt_host ? host_wd : cpu_wd;
    assign mem_we   = (gnt_cpu & cpu_we) | (gnt_host & host_we);

    assign cpu_rd  = mem_rd;
    assign host_rd = mem_rd;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (cpu_stall),
        .count(stall_cnt)
    );

endmodule
